// File: rtl/shift_universal_pkg.sv
// rtl/shift_universal_pkg.sv - shared types for the universal shift register
package shift_pkg;

    typedef enum logic [2:0] {
        HOLD = 3'd0,
        SHL  = 3'd1,
        SHR  = 3'd2,
        ROL  = 3'd3,
        ROR  = 3'd4,
        ASR  = 3'd5
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Codes 0, 6 and 7 move no bit out, so they leave ser_out alone.
    function automatic logic moves_bit(input logic [2:0] m);
        return (m >= 3'(SHL)) && (m <= 3'(ASR));
    endfunction

endpackage

// File: rtl/shift_universal_if.sv
// rtl/shift_universal_if.sv - control/data bundle between requester and shifter
interface shift_universal_if #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
);
    logic              load_enable;
    logic [WIDTH-1:0]  in;
    logic [2:0]        mode;
    logic              ser_in;
    logic              start;
    logic [STEP_W-1:0] count;
    logic [WIDTH-1:0]  q;
    logic              ser_out;
    logic              busy;
    logic              done;

    modport master (
        output load_enable, in, mode, ser_in, start, count,
        input  q, ser_out, busy, done
    );

    modport slave (
        input  load_enable, in, mode, ser_in, start, count,
        output q, ser_out, busy, done
    );
endinterface

// File: rtl/shift_universal_step.sv
// rtl/shift_universal_step.sv - combinational single-step shift/rotate datapath
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       mode,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q_next,
    output logic             bit_out
);

    always_comb begin
        q_next  = q;
        bit_out = 1'b0;
        case (mode)
            3'(SHL): begin
                q_next  = {q[WIDTH-2:0], ser_in};
                bit_out = q[WIDTH-1];
            end
            3'(SHR): begin
                q_next  = {ser_in, q[WIDTH-1:1]};
                bit_out = q[0];
            end
            3'(ROL): begin
                q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
                bit_out = q[WIDTH-1];
            end
            3'(ROR): begin
                q_next  = {q[0], q[WIDTH-1:1]};
                bit_out = q[0];
            end
            3'(ASR): begin
                q_next  = {q[WIDTH-1], q[WIDTH-1:1]};
                bit_out = q[0];
            end
            default: begin
                q_next  = q;
                bit_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_universal.sv
// rtl/shift_universal.sv - universal shift register with N-step sequencer
module shift_universal
    import shift_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    shift_universal_if.slave bus
);

    state_t            state;
    logic [WIDTH-1:0]  q_r;
    logic [2:0]        mode_r;
    logic [STEP_W-1:0] rem;
    logic              ser_out_r;
    logic [WIDTH-1:0]  q_next;
    logic              bit_out;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .q      (q_r),
        .mode   (mode_r),
        .ser_in (bus.ser_in),
        .q_next (q_next),
        .bit_out(bit_out)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            q_r       <= '0;
            mode_r    <= 3'(HOLD);
            rem       <= '0;
            ser_out_r <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.load_enable) begin
                        q_r   <= bus.in;
                        state <= IDLE;
                    end else if (bus.start) begin
                        if (bus.count != '0) begin
                            mode_r <= bus.mode;
                            rem    <= bus.count;
                            state  <= RUN;
                        end else begin
                            state <= DONE;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    // A load mid-operation aborts without a done pulse.
                    if (bus.load_enable) begin
                        q_r   <= bus.in;
                        rem   <= '0;
                        state <= IDLE;
                    end else begin
                        q_r <= q_next;
                        rem <= rem - STEP_W'(1);
                        if (moves_bit(mode_r))
                            ser_out_r <= bit_out;
                        if (rem == STEP_W'(1))
                            state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.q       = q_r;
    assign bus.ser_out = ser_out_r;
    assign bus.busy    = (state == RUN);
    assign bus.done    = (state == DONE);

endmodule
